uart_port: RTL and testbench



---
 rtl/uart_port.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_uart_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// uart_port: parametrised UART on the outbus/inbus register interface.
// Four-register window at DEVADDR, 16x oversampling baud generator,
// TX/RX FIFOs and sticky receive error flags.

// Circular FIFO with a combinational read port at the head entry.
module uart_port_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned POWER = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned DEPTH = 1 << POWER;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [POWER-1:0] wptr_q, rptr_q;
  logic [POWER:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (POWER+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy tracking; pointers wrap at 2^POWER.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module uart_port #(
  parameter logic [7:0]  DEVADDR    = 8'h00,
  parameter logic [15:0] CLK_DIV    = 16'd27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_POWER = 4
) (
  input  logic       cpu_clk,
  input  logic       reset,
  output logic       reset_complete,
  input  logic       rx_pin,
  output logic       tx_pin,
  input  logic [7:0] outbus_addr,
  input  logic [7:0] outbus_data,
  input  logic       outbus_we,
  input  logic [7:0] inbus_addr,
  input  logic       inbus_re,
  output logic [7:0] inbus_data
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 2);

  // Power-up value is 0; the first reset edge sets it for good.
  logic rc_q = 1'b0;

  // Latches the fact that a reset has been seen.
  always_ff @(posedge cpu_clk) begin
    if (reset) rc_q <= 1'b1;
  end
  assign reset_complete = rc_q;

  // ---------------- baud generator ----------------
  logic [15:0] div_q;
  logic        tick;
  assign tick = (div_q == CLK_DIV - 16'd1);

  // Free-running oversample divider, held at 0 during reset.
  always_ff @(posedge cpu_clk) begin
    if (reset || tick) div_q <= '0;
    else               div_q <= div_q + 16'd1;
  end

  // ---------------- bus decode ----------------
  logic [7:0] wr_off, rd_off;
  logic       tx_push, rd_txstat, rd_rxdata, rd_rxstat;
  assign wr_off    = outbus_addr - DEVADDR;
  assign rd_off    = inbus_addr - DEVADDR;
  assign tx_push   = outbus_we && (wr_off == 8'd0);
  assign rd_txstat = inbus_re && (rd_off == 8'd1);
  assign rd_rxdata = inbus_re && (rd_off == 8'd2);
  assign rd_rxstat = inbus_re && (rd_off == 8'd3);

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] tx_rdata, rx_rdata, rx_shift_q, rx_shift_d;
  logic tx_pop, tx_empty, tx_full;
  logic rx_push, rx_empty, rx_full;

  uart_port_fifo #(.WIDTH(DATA_BITS), .POWER(FIFO_POWER)) u_tx_fifo (
    .clk_i(cpu_clk), .rst_i(reset), .push_i(tx_push),
    .wdata_i(outbus_data[DATA_BITS-1:0]), .pop_i(tx_pop),
    .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full)
  );

  uart_port_fifo #(.WIDTH(DATA_BITS), .POWER(FIFO_POWER)) u_rx_fifo (
    .clk_i(cpu_clk), .rst_i(reset), .push_i(rx_push),
    .wdata_i(rx_shift_q), .pop_i(rd_rxdata),
    .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full)
  );

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_sub_q, tx_sub_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_q, tx_d;
  logic                 tx_bit_end, tx_load;
  logic                 tx_busy;

  assign tx_bit_end = tick && (tx_sub_q == 4'd15);
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign tx_pin     = tx_q;

  // TX state register.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state; a frame loads from IDLE or directly from the last stop
  // bit, so back-to-back frames carry no extra idle time.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    if (tick && (tx_state_q != TX_IDLE)) tx_sub_d = tx_sub_q + 4'd1;
    case (tx_state_q)
      TX_IDLE:  if (tick && !tx_empty) tx_load = 1'b1;
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit_q == 3'(DATA_BITS-1)) begin
          tx_bit_d = '0;
          if (PAR_EN) begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_d[0];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_bit_d = '0;
        if (tx_bit_q == 3'(STOP_BITS-1)) begin
          if (!tx_empty) tx_load = 1'b1;
          else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_bit_d   = '0;
      tx_d       = 1'b0;
      tx_shift_d = tx_rdata;
      tx_par_d   = (^tx_rdata) ^ PAR_ODD;
    end
  end

  // ---------------- receiver ----------------
  logic       rx_meta_q, rx_sync_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_sub_q, rx_sub_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_parbit_q, rx_parbit_d;
  logic       rx_sample, set_fe, set_pe, set_ov;

  assign rx_sample = tick && (rx_sub_q == 4'd15);
  assign set_ov    = rx_push && rx_full;

  // Two-flop synchroniser on the asynchronous serial input.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state register.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      rx_sub_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_parbit_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_sub_q    <= rx_sub_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_parbit_q <= rx_parbit_d;
    end
  end

  // RX next state; samples at mid-bit and checks only the first stop bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_sub_d    = rx_sub_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_parbit_d = rx_parbit_q;
    rx_push     = 1'b0;
    set_fe      = 1'b0;
    set_pe      = 1'b0;
    if (tick && (rx_state_q != RX_IDLE)) rx_sub_d = rx_sub_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: if (tick && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_sub_d   = '0;
      end
      RX_START: if (tick && (rx_sub_q == 4'd7)) begin
        rx_sub_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == 3'(DATA_BITS-1)) begin
          rx_bit_d   = '0;
          rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: if (rx_sample) begin
        rx_parbit_d = rx_sync_q;
        rx_state_d  = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_state_d = RX_IDLE;
        if (!rx_sync_q) set_fe = 1'b1;
        else begin
          rx_push = 1'b1;
          if (PAR_EN && (((^rx_shift_q) ^ PAR_ODD) != rx_parbit_q)) set_pe = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- sticky flags and read port ----------------
  logic fe_q, pe_q, ov_q;
  logic [7:0] rx_ext, rdata_d, rdata_q;

  // Sticky error flags; a setting event wins over a same-cycle clear.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      fe_q <= 1'b0;
      pe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= (fe_q & ~rd_rxstat) | set_fe;
      pe_q <= (pe_q & ~rd_rxstat) | set_pe;
      ov_q <= (ov_q & ~rd_rxstat) | set_ov;
    end
  end

  // Read mux; anything but a valid read returns 0.
  always_comb begin
    rx_ext = '0;
    rx_ext[DATA_BITS-1:0] = rx_rdata;
    rdata_d = '0;
    if (rd_txstat)      rdata_d = {5'b0, tx_busy, tx_full, ~tx_empty};
    else if (rd_rxdata) rdata_d = rx_empty ? 8'hFF : rx_ext;
    else if (rd_rxstat) rdata_d = {3'b0, ov_q, pe_q, fe_q, rx_full, ~rx_empty};
  end

  // Registered read data, valid for one cycle after the read edge.
  always_ff @(posedge cpu_clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end
  assign inbus_data = rdata_q;
endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port: three instances (8N1 @0x00, 8E2 loopback
// @0x10, 8O1 @0x20) share one bus, CLK_DIV=4 so one bit = 64 cycles.
module tb_uart_port;
  localparam int BIT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [7:0] oaddr = '0, odata = '0, iaddr = '0;
  logic       owe = 1'b0, ire = 1'b0;
  logic       rx_a = 1'b1, rx_c = 1'b1;
  logic       tx_a, tx_b, tx_c, rc_a, rc_b, rc_c;
  logic [7:0] d_a, d_b, d_c, rdata;
  assign rdata = d_a | d_b | d_c;

  int vectors = 0;
  int errors  = 0;

  uart_port #(.DEVADDR(8'h00), .CLK_DIV(16'd4), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .FIFO_POWER(4)) u_n1 (
    .cpu_clk(clk), .reset(reset), .reset_complete(rc_a), .rx_pin(rx_a), .tx_pin(tx_a),
    .outbus_addr(oaddr), .outbus_data(odata), .outbus_we(owe),
    .inbus_addr(iaddr), .inbus_re(ire), .inbus_data(d_a));

  uart_port #(.DEVADDR(8'h10), .CLK_DIV(16'd4), .DATA_BITS(8), .PARITY(1),
              .STOP_BITS(2), .FIFO_POWER(4)) u_e2 (
    .cpu_clk(clk), .reset(reset), .reset_complete(rc_b), .rx_pin(tx_b), .tx_pin(tx_b),
    .outbus_addr(oaddr), .outbus_data(odata), .outbus_we(owe),
    .inbus_addr(iaddr), .inbus_re(ire), .inbus_data(d_b));

  uart_port #(.DEVADDR(8'h20), .CLK_DIV(16'd4), .DATA_BITS(8), .PARITY(2),
              .STOP_BITS(1), .FIFO_POWER(4)) u_o1 (
    .cpu_clk(clk), .reset(reset), .reset_complete(rc_c), .rx_pin(rx_c), .tx_pin(tx_c),
    .outbus_addr(oaddr), .outbus_data(odata), .outbus_we(owe),
    .inbus_addr(iaddr), .inbus_re(ire), .inbus_data(d_c));

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    oaddr = a; odata = d; owe = 1'b1;
    @(negedge clk);
    owe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    iaddr = a; ire = 1'b1;
    @(posedge clk);
    #1 d = rdata;
    ire = 1'b0;
  endtask

  task automatic set_rx(input int which, input logic b);
    if (which == 0) rx_a = b;
    else            rx_c = b;
  endtask

  // Drives n bits LSB first, one bit time each, then returns the line high.
  task automatic drive_frame(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      repeat (BIT) @(posedge clk);
    end
    set_rx(which, 1'b1);
  endtask

  // Waits at negedges for a tx pin to go low; cnt returns the poll count.
  task automatic wait_tx_low(input int which, inout int cnt);
    while (((which == 0) ? tx_a : tx_b) !== 1'b0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    vectors++;
    if ({rc_a, rc_b, rc_c} !== 3'b000) begin
      $display("FAIL reset_complete_powerup got %b want 000", {rc_a, rc_b, rc_c}); errors++;
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({rc_a, rc_b, rc_c} !== 3'b111) begin
      $display("FAIL reset_complete_set got %b want 111", {rc_a, rc_b, rc_c}); errors++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({tx_a, tx_b, tx_c} !== 3'b111 || rdata !== 8'h00) begin
      $display("FAIL reset_outputs got tx=%b data=%h want tx=111 data=00", {tx_a, tx_b, tx_c}, rdata); errors++;
    end
    reset = 1'b0;
    bus_read(8'h01, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL reset_txstat got %h want 00", r); errors++; end
    bus_read(8'h13, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL reset_rxstat got %h want 00", r); errors++; end
    bus_read(8'h00, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL read_wo_addr got %h want 00", r); errors++; end
  endtask

  task automatic test_basic_tx();
    logic [7:0] pat;
    logic exp, bad, busybad;
    int cnt, idx;
    pat = 8'h55;
    bus_write(8'h00, pat);
    iaddr = 8'h01; ire = 1'b1;
    cnt = 1;
    wait_tx_low(0, cnt);
    vectors++;
    if (cnt < 2 || cnt > 6) begin
      $display("FAIL tx_start_latency got %0d want 2..6", cnt); errors++;
    end
    bad = 1'b0; busybad = 1'b0;
    for (int k = 0; k < 640; k++) begin
      if (k > 0) @(negedge clk);
      idx = k / BIT;
      exp = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : pat[idx-1];
      if (tx_a !== exp) bad = 1'b1;
      if (k > 0 && rdata[2:0] !== 3'b100) busybad = 1'b1;
      if (k % BIT == BIT - 1) begin
        vectors++;
        if (bad) begin $display("FAIL basic_tx_bit%0d got %b want %b", idx, tx_a, exp); errors++; end
        bad = 1'b0;
      end
    end
    vectors++;
    if (busybad) begin $display("FAIL basic_tx_busy got %b want 100 during frame", rdata[2:0]); errors++; end
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_a !== 1'b1 || rdata[2:0] !== 3'b000) begin
      $display("FAIL basic_tx_idle got tx=%b stat=%b want tx=1 stat=000", tx_a, rdata[2:0]); errors++;
    end
    ire = 1'b0;
  endtask

  task automatic test_loopback();
    logic [7:0] r;
    logic [7:0] exp_b [4];
    int cnt;
    exp_b[0] = 8'h07; exp_b[1] = 8'hA5; exp_b[2] = 8'h00; exp_b[3] = 8'hFF;
    bus_write(8'h10, 8'h07);
    cnt = 0;
    wait_tx_low(1, cnt);
    vectors++;
    if (cnt >= 40) begin $display("FAIL loop_start got timeout want tx low"); errors++; end
    bus_write(8'h10, 8'hA5);
    bus_write(8'h10, 8'h00);
    repeat (9 * BIT + 32 - 4) @(negedge clk);
    vectors++;
    if (tx_b !== 1'b1) begin $display("FAIL loop_parity07 got %b want 1", tx_b); errors++; end
    repeat (128) @(negedge clk);
    vectors++;
    if (tx_b !== 1'b1) begin $display("FAIL loop_stop2 got %b want 1", tx_b); errors++; end
    repeat (64) @(negedge clk);
    vectors++;
    if (tx_b !== 1'b0) begin $display("FAIL loop_b2b_start got %b want 0", tx_b); errors++; end
    repeat (1600) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h12, r);
      vectors++;
      if (r !== exp_b[i]) begin $display("FAIL loop_rx%0d got %h want %h", i, r, exp_b[i]); errors++; end
    end
    bus_read(8'h13, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL loop_status got %h want 00", r); errors++; end
  endtask

  task automatic test_framing();
    logic [7:0] r;
    drive_frame(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    repeat (200) @(negedge clk);
    bus_read(8'h03, r);
    vectors++;
    if (r !== 8'h04) begin $display("FAIL framing_status got %h want 04", r); errors++; end
    bus_read(8'h02, r);
    vectors++;
    if (r !== 8'hFF) begin $display("FAIL framing_empty got %h want FF", r); errors++; end
    bus_read(8'h03, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL framing_clear got %h want 00", r); errors++; end
  endtask

  task automatic test_parity();
    logic [7:0] r;
    drive_frame(1, {5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
    repeat (200) @(negedge clk);
    bus_read(8'h23, r);
    vectors++;
    if (r !== 8'h09) begin $display("FAIL parity_status got %h want 09", r); errors++; end
    bus_read(8'h22, r);
    vectors++;
    if (r !== 8'h01) begin $display("FAIL parity_data got %h want 01", r); errors++; end
    bus_read(8'h23, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL parity_clear got %h want 00", r); errors++; end
  endtask

  task automatic test_overrun();
    logic [7:0] r, b;
    for (int i = 0; i < 17; i++) begin
      b = 8'h40 + 8'(i);
      drive_frame(0, {6'b0, 1'b1, b, 1'b0}, 10);
      repeat (BIT) @(posedge clk);
    end
    bus_read(8'h03, r);
    vectors++;
    if (r !== 8'h13) begin $display("FAIL overrun_status got %h want 13", r); errors++; end
    for (int i = 0; i < 16; i++) begin
      b = 8'h40 + 8'(i);
      bus_read(8'h02, r);
      vectors++;
      if (r !== b) begin $display("FAIL overrun_rx%0d got %h want %h", i, r, b); errors++; end
    end
    bus_read(8'h02, r);
    vectors++;
    if (r !== 8'hFF) begin $display("FAIL overrun_drained got %h want FF", r); errors++; end
    bus_read(8'h03, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL overrun_clear got %h want 00", r); errors++; end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] r;
    int cnt;
    bus_write(8'h00, 8'hF0);
    cnt = 0;
    wait_tx_low(0, cnt);
    repeat (280) @(negedge clk);
    vectors++;
    if (tx_a !== 1'b0) begin $display("FAIL midreset_bit3 got %b want 0", tx_a); errors++; end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (tx_a !== 1'b1 || rc_a !== 1'b1) begin
      $display("FAIL midreset_pin got tx=%b rc=%b want tx=1 rc=1", tx_a, rc_a); errors++;
    end
    @(negedge clk) reset = 1'b0;
    bus_read(8'h01, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL midreset_txstat got %h want 00", r); errors++; end
    repeat (300) @(negedge clk);
    vectors++;
    if (tx_a !== 1'b1) begin $display("FAIL midreset_abandon got %b want 1", tx_a); errors++; end
  endtask

  task automatic test_false_start();
    logic [7:0] r;
    @(negedge clk) rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(8'h03, r);
    vectors++;
    if (r !== 8'h00) begin $display("FAIL false_start_status got %h want 00", r); errors++; end
    bus_read(8'h02, r);
    vectors++;
    if (r !== 8'hFF) begin $display("FAIL false_start_empty got %h want FF", r); errors++; end
  endtask

  initial begin
    test_reset();
    test_basic_tx();
    test_loopback();
    test_framing();
    test_parity();
    test_overrun();
    test_midframe_reset();
    test_false_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
